ksa_shuffle_ctrl: RTL and testbench

//  Sequences the RC4 key-scheduling shuffle over the 256x8 single-port S memory (s_memory).

---
 rtl/ksa_shuffle_ctrl.sv | 145 ++++++++++++++
 tb/tb_ksa_shuffle_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ksa_shuffle_ctrl.sv
// RC4 key-scheduling shuffle sequencer for a 256x8 single-port S memory.
// Each iteration: read S[i], update j, read S[j], then write the swap (S[i] first, then S[j]).
module ksa_shuffle_ctrl #(
  parameter int KEY_LEN  = 3,
  parameter int READ_LAT = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] secret_key,
  output logic [7:0]           mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_wren,
  input  logic [7:0]           mem_q,
  output logic                 busy,
  output logic                 done
);

  localparam int KW  = (KEY_LEN  > 1) ? $clog2(KEY_LEN)  : 1;
  localparam int WCW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [KW-1:0]  K_LAST = KW'(KEY_LEN - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'((READ_LAT > 1) ? READ_LAT - 2 : 0);

  typedef enum logic [3:0] {
    IDLE, RD_I, WAIT_I, GET_I, RD_J, WAIT_J, GET_J, WR_I, WR_J, DONE
  } state_t;

  state_t               state, state_nxt;
  logic [7:0]           i_r, i_nxt, j_r, j_nxt, si_r, si_nxt, sj_r, sj_nxt;
  logic [KW-1:0]        k_r, k_nxt;
  logic [WCW-1:0]       w_r, w_nxt;
  logic [8*KEY_LEN-1:0] key_r, key_nxt;
  logic [7:0]           kbyte;

  // Key byte 0 is the most significant byte of the latched key.
  always_comb begin
    kbyte = key_r[8*KEY_LEN-1 -: 8];
    for (int b = 0; b < KEY_LEN; b++)
      if (k_r == KW'(b)) kbyte = key_r[8*(KEY_LEN-b)-1 -: 8];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      i_r   <= '0;
      j_r   <= '0;
      k_r   <= '0;
      w_r   <= '0;
      si_r  <= '0;
      sj_r  <= '0;
      key_r <= '0;
    end else begin
      state <= state_nxt;
      i_r   <= i_nxt;
      j_r   <= j_nxt;
      k_r   <= k_nxt;
      w_r   <= w_nxt;
      si_r  <= si_nxt;
      sj_r  <= sj_nxt;
      key_r <= key_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    i_nxt     = i_r;
    j_nxt     = j_r;
    k_nxt     = k_r;
    w_nxt     = w_r;
    si_nxt    = si_r;
    sj_nxt    = sj_r;
    key_nxt   = key_r;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state)
      IDLE, DONE: begin
        busy = 1'b0;
        done = (state == DONE);
        if (start) begin
          state_nxt = RD_I;
          key_nxt   = secret_key;
          i_nxt     = '0;
          j_nxt     = '0;
          k_nxt     = '0;
        end
      end
      RD_I: begin
        mem_addr  = i_r;
        w_nxt     = '0;
        state_nxt = (READ_LAT > 1) ? WAIT_I : GET_I;
      end
      WAIT_I: begin
        mem_addr = i_r;
        if (w_r == W_LAST) state_nxt = GET_I;
        else               w_nxt     = w_r + WCW'(1);
      end
      GET_I: begin
        mem_addr  = i_r;
        si_nxt    = mem_q;
        j_nxt     = j_r + mem_q + kbyte;
        state_nxt = RD_J;
      end
      RD_J: begin
        mem_addr  = j_r;
        w_nxt     = '0;
        state_nxt = (READ_LAT > 1) ? WAIT_J : GET_J;
      end
      WAIT_J: begin
        mem_addr = j_r;
        if (w_r == W_LAST) state_nxt = GET_J;
        else               w_nxt     = w_r + WCW'(1);
      end
      GET_J: begin
        mem_addr  = j_r;
        sj_nxt    = mem_q;
        state_nxt = WR_I;
      end
      WR_I: begin
        mem_addr  = i_r;
        mem_wdata = sj_r;
        mem_wren  = 1'b1;
        state_nxt = WR_J;
      end
      WR_J: begin
        // When i==j both writes hit the same address with si, leaving S unchanged.
        mem_addr  = j_r;
        mem_wdata = si_r;
        mem_wren  = 1'b1;
        k_nxt     = (k_r == K_LAST) ? '0 : k_r + KW'(1);
        if (i_r == 8'hFF) begin
          state_nxt = DONE;
        end else begin
          i_nxt     = i_r + 8'd1;
          state_nxt = RD_I;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ksa_shuffle_ctrl.sv
// Bench for ksa_shuffle_ctrl: S memory model (2-cycle read) plus a software RC4 KSA reference.
module tb_ksa_shuffle_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [23:0] secret_key;
  logic [7:0]  mem_addr, mem_wdata, mem_q;
  logic        mem_wren, busy, done;

  always #5 clk = ~clk;

  ksa_shuffle_ctrl #(.KEY_LEN(3), .READ_LAT(2)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .secret_key(secret_key),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy), .done(done)
  );

  // S memory: registered address then registered data, so q is valid two clocks after addr.
  logic [7:0] mem    [256];
  logic [7:0] init_s [256];
  logic       fill;
  logic [7:0] a_d;

  always @(posedge clk) begin
    if (fill) for (int a = 0; a < 256; a++) mem[a] <= init_s[a];
    else if (mem_wren) mem[mem_addr] <= mem_wdata;
    a_d   <= mem_addr;
    mem_q <= mem[a_d];
  end

  int vectors = 0, errors = 0;
  int cyc = 0, busy_cnt = 0, wr_idx = 0, exp_n = 0;
  int last_wr_cyc = -1, first_done_cyc = -1;
  logic done_prev = 1'b0;
  logic [7:0] rs [256];
  logic [7:0] t2_final [256];
  int exp_addr [512], exp_data [512], log_addr [512], log_data [512];

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // One clock; outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (mem_wren) begin
      if (wr_idx < exp_n) begin
        chk("wr_addr", int'(mem_addr), exp_addr[wr_idx]);
        chk("wr_data", int'(mem_wdata), exp_data[wr_idx]);
      end else begin
        chk("write_not_expected", int'(mem_wren), 0);
      end
      if (wr_idx < 512) begin
        log_addr[wr_idx] = int'(mem_addr);
        log_data[wr_idx] = int'(mem_wdata);
      end
      wr_idx++;
      last_wr_cyc = cyc;
    end
    if (!busy) chk("wren_while_not_busy", int'(mem_wren), 0);
    chk("busy_and_done", int'(busy & done), 0);
    if (busy) busy_cnt++;
    if (done && !done_prev) first_done_cyc = cyc;
    done_prev = done;
    cyc++;
  endtask

  // Reference RC4 KSA on a copy of init_s; records the expected write sequence.
  task automatic build_exp(input logic [23:0] key);
    logic [7:0] j, kb, t;
    j = 8'd0;
    for (int a = 0; a < 256; a++) rs[a] = init_s[a];
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (2 - (i % 3))));
      j  = j + rs[i] + kb;
      exp_addr[2*i]   = i;
      exp_data[2*i]   = int'(rs[j]);
      exp_addr[2*i+1] = int'(j);
      exp_data[2*i+1] = int'(rs[i]);
      t = rs[i]; rs[i] = rs[j]; rs[j] = t;
    end
    exp_n  = 512;
    wr_idx = 0;
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) init_s[a] = 8'(a);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_addr"}, int'(mem_addr), 0);
    chk({nm, "_wren"}, int'(mem_wren), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
  endtask

  // glitch_at: busy cycle at which start is pulsed with a new key; rst_at: busy cycle for reset.
  task automatic run(input logic [23:0] key, input int glitch_at, input int rst_at);
    int b0, n, nmis;
    fill = 1'b1; tick(); fill = 1'b0; tick();
    build_exp(key);
    b0 = busy_cnt; first_done_cyc = -1; last_wr_cyc = -1;
    secret_key = key; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      if (glitch_at >= 0 && busy_cnt - b0 == glitch_at) begin
        start = 1'b1; secret_key = 24'($urandom);
      end else begin
        start = 1'b0;
      end
      if (rst_at >= 0 && busy_cnt - b0 == rst_at) begin
        reset = 1'b1; tick(); reset = 1'b0;
        check_reset_outputs("midrun_reset");
        exp_n = wr_idx;
        repeat (40) tick();
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_done", int'(done), 0);
        return;
      end
      tick(); n++;
    end
    start = 1'b0;
    if (!done) chk("run_timeout_done", int'(done), 1);
    tick(); tick();
    chk("write_count", wr_idx, 512);
    chk("busy_cycles", busy_cnt - b0, 2048);
    chk("done_after_last_wr", first_done_cyc, last_wr_cyc + 1);
    chk("done_level", int'(done), 1);
    nmis = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== rs[a]) nmis++;
    chk("final_s_bytes_wrong", nmis, 0);
  endtask

  initial begin
    int nmis;
    logic [7:0] t;
    int r;
    reset = 1'b1; start = 1'b0; secret_key = '0; fill = 1'b0;
    set_identity();
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0; tick();
    check_reset_outputs("idle");

    // Key 010203 on identity S
    run(24'h010203, -1, -1);
    chk("model_w0_addr", exp_addr[0], 0);
    chk("model_w0_data", exp_data[0], 1);
    chk("model_iter1_j", exp_addr[3], 3);
    chk("t2_w0_addr", log_addr[0], 0);
    chk("t2_w0_data", log_data[0], 1);
    chk("t2_w1_addr", log_addr[1], 1);
    chk("t2_w1_data", log_data[1], 0);
    chk("t2_w2_addr", log_addr[2], 1);
    chk("t2_w2_data", log_data[2], 3);
    chk("t2_w3_addr", log_addr[3], 3);
    chk("t2_w3_data", log_data[3], 0);
    for (int a = 0; a < 256; a++) t2_final[a] = rs[a];

    // Reset while in DONE
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_outputs("reset_in_done");

    // All-zero key: iteration 1 has i == j == 1
    set_identity();
    run(24'h000000, -1, -1);
    chk("t3_w2_addr", log_addr[2], 1);
    chk("t3_w2_data", log_data[2], 1);
    chk("t3_w3_addr", log_addr[3], 1);
    chk("t3_w3_data", log_data[3], 1);

    // Timing run, then the same run with a start pulse and key change mid-shuffle
    set_identity();
    run(24'h000249, -1, -1);
    set_identity();
    run(24'h000249, 500, -1);
    secret_key = 24'h000249;

    // Reset partway through, then refill and rerun key 010203
    set_identity();
    run(24'h0a0b0c, -1, 100);
    set_identity();
    run(24'h010203, -1, -1);
    nmis = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== t2_final[a]) nmis++;
    chk("rerun_matches_t2", nmis, 0);

    // Random keys on identity S, then a random key on a random permutation
    repeat (3) begin
      set_identity();
      run(24'($urandom), -1, -1);
    end
    set_identity();
    for (int a = 255; a > 0; a--) begin
      r = $urandom_range(a, 0);
      t = init_s[a]; init_s[a] = init_s[r]; init_s[r] = t;
    end
    run(24'($urandom), -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
